// File: rtl/psk_pkg.sv
// Shared definitions for the PSK modulator: mode encoding, FSM states and the
// default constellation amplitude.
package psk_pkg;

    typedef enum logic {
        MODE_BPSK = 1'b0,
        MODE_QPSK = 1'b1
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEFAULT_AMP = 8192;

endpackage

// File: rtl/psk_symbol_map.sv
// Combinational constellation mapper: two bits (b_hi, b_lo) to signed I/Q.
// In BPSK only b_hi is used and drives both rails identically.
module psk_symbol_map
    import psk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMP   = DEFAULT_AMP
) (
    input  logic                    mode,
    input  logic [1:0]              bits,
    output logic signed [WIDTH-1:0] i_sym,
    output logic signed [WIDTH-1:0] q_sym
);

    localparam logic signed [WIDTH-1:0] POS = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] NEG = -POS;

    logic q_bit;

    always_comb begin
        q_bit = (mode == MODE_QPSK) ? bits[0] : bits[1];
        i_sym = bits[1] ? NEG : POS;
        q_sym = q_bit ? NEG : POS;
    end

endmodule

// File: rtl/psk_modulator.sv
// Byte-stream BPSK/QPSK modulator: each accepted byte becomes 8 (BPSK) or
// 4 (QPSK) symbols, MSB first, each held SPS cycles on registered I/Q outputs.
module psk_modulator
    import psk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SPS   = 4,
    parameter int AMP   = DEFAULT_AMP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [7:0]              s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic signed [WIDTH-1:0] I_tdata,
    output logic                    I_tvalid,
    output logic signed [WIDTH-1:0] Q_tdata,
    output logic                    Q_tvalid,
    output logic                    busy
);

    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SPS - 1);

    state_t                  state;
    logic [CW-1:0]           sample_cnt;
    logic [2:0]              sym_cnt;
    logic [7:0]              shift_reg;
    logic                    mode_reg;

    logic                    accept;
    logic                    sample_last;
    logic                    sym_last;
    logic [2:0]              sym_max;
    logic [7:0]              shift_next;
    logic                    map_mode;
    logic [1:0]              map_bits;
    logic signed [WIDTH-1:0] map_i;
    logic signed [WIDTH-1:0] map_q;

    // One mapper serves both a freshly accepted byte and the next symbol of the current one.
    always_comb begin
        accept      = s_tvalid && s_tready;
        sample_last = (sample_cnt == SAMPLE_LAST);
        sym_max     = (mode_reg == MODE_QPSK) ? 3'd3 : 3'd7;
        sym_last    = (sym_cnt == sym_max);
        shift_next  = (mode_reg == MODE_QPSK) ? {shift_reg[5:0], 2'b00}
                                              : {shift_reg[6:0], 1'b0};
        map_mode    = accept ? mode : mode_reg;
        map_bits    = accept ? s_tdata[7:6] : shift_next[7:6];
    end

    psk_symbol_map #(
        .WIDTH (WIDTH),
        .AMP   (AMP)
    ) u_map (
        .mode  (map_mode),
        .bits  (map_bits),
        .i_sym (map_i),
        .q_sym (map_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            sym_cnt    <= '0;
            shift_reg  <= '0;
            mode_reg   <= 1'b0;
            I_tdata    <= '0;
            Q_tdata    <= '0;
            I_tvalid   <= 1'b0;
            Q_tvalid   <= 1'b0;
            busy       <= 1'b0;
            s_tready   <= 1'b0;
        end else if (accept) begin
            state      <= SEND;
            mode_reg   <= mode;
            shift_reg  <= s_tdata;
            sample_cnt <= '0;
            sym_cnt    <= '0;
            I_tdata    <= map_i;
            Q_tdata    <= map_q;
            I_tvalid   <= 1'b1;
            Q_tvalid   <= 1'b1;
            busy       <= 1'b1;
            s_tready   <= 1'b0;
        end else if (state == IDLE) begin
            s_tready <= 1'b1;
        end else if (!sample_last) begin
            sample_cnt <= sample_cnt + CW'(1);
            s_tready   <= ((sample_cnt + CW'(1)) == SAMPLE_LAST) && sym_last;
        end else if (!sym_last) begin
            sample_cnt <= '0;
            sym_cnt    <= sym_cnt + 3'd1;
            shift_reg  <= shift_next;
            I_tdata    <= map_i;
            Q_tdata    <= map_q;
            s_tready   <= (SPS == 1) && ((sym_cnt + 3'd1) == sym_max);
        end else begin
            // Underflow: last sample sent and nothing offered.
            state      <= IDLE;
            sample_cnt <= '0;
            sym_cnt    <= '0;
            I_tdata    <= '0;
            Q_tdata    <= '0;
            I_tvalid   <= 1'b0;
            Q_tvalid   <= 1'b0;
            busy       <= 1'b0;
            s_tready   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psk_modulator.sv
// Self-checking bench for psk_modulator: directed scenarios plus random traffic,
// compared every cycle against a queue-of-expected-samples reference model.
module tb_psk_modulator;
    import psk_pkg::*;

    localparam int WIDTH = 16;
    localparam int SPS   = 4;
    localparam int AMP   = 8192;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    mode = 1'b0;
    logic [7:0]              s_tdata = 8'h00;
    logic                    s_tvalid = 1'b0;
    logic                    s_tready;
    logic signed [WIDTH-1:0] I_tdata;
    logic                    I_tvalid;
    logic signed [WIDTH-1:0] Q_tdata;
    logic                    Q_tvalid;
    logic                    busy;

    psk_modulator #(
        .WIDTH (WIDTH),
        .SPS   (SPS),
        .AMP   (AMP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .I_tdata  (I_tdata),
        .I_tvalid (I_tvalid),
        .Q_tdata  (Q_tdata),
        .Q_tvalid (Q_tvalid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
    } samp_t;

    samp_t exp_q[$];
    bit    ready_ok = 1'b0;
    int    cur_i = 0;
    int    cur_q = 0;
    int    cur_v = 0;
    bit    last_acc = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    cycle = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cycle, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return ready_ok && (exp_q.size() == 0);
    endfunction

    // Expand a byte into its expected sample stream from the constellation rules.
    task automatic push_byte(input logic [7:0] b, input logic m);
        int nsym;
        bit hi;
        bit lo;
        samp_t s;
        nsym = m ? 4 : 8;
        for (int k = 0; k < nsym; k++) begin
            if (m) begin
                hi = b[7 - 2 * k];
                lo = b[6 - 2 * k];
            end else begin
                hi = b[7 - k];
                lo = hi;
            end
            s.i = hi ? -AMP : AMP;
            s.q = lo ? -AMP : AMP;
            repeat (SPS) exp_q.push_back(s);
        end
    endtask

    task automatic check_outputs(input int exp_ready);
        check("s_tready", {31'b0, s_tready}, exp_ready);
        check("I_tdata", I_tdata, cur_i);
        check("Q_tdata", Q_tdata, cur_q);
        check("I_tvalid", {31'b0, I_tvalid}, cur_v);
        check("Q_tvalid", {31'b0, Q_tvalid}, cur_v);
        check("busy", {31'b0, busy}, cur_v);
    endtask

    task automatic step(input bit v, input logic [7:0] d, input logic m);
        samp_t s;
        s_tvalid = v;
        s_tdata  = d;
        mode     = m;
        @(posedge clk);
        cycle++;
        last_acc = v && model_ready();
        if (last_acc) begin
            push_byte(d, m);
            $display("cycle %0d: accept byte 0x%02h mode %s", cycle, d, m ? "QPSK" : "BPSK");
        end
        ready_ok = 1'b1;
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            cur_i = s.i;
            cur_q = s.q;
            cur_v = 1;
        end else begin
            cur_i = 0;
            cur_q = 0;
            cur_v = 0;
        end
        #1;
        check_outputs(model_ready() ? 1 : 0);
    endtask

    task automatic send(input logic [7:0] d, input logic m);
        for (int n = 0; n < 100; n++) begin
            step(1'b1, d, m);
            if (last_acc) break;
        end
        if (!last_acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, mode);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        exp_q.delete();
        ready_ok = 1'b0;
        cur_i = 0;
        cur_q = 0;
        cur_v = 0;
        $display("cycle %0d: async reset", cycle);
        check_outputs(0);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int accepted;
        logic m;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(0);
        rst = 1'b1;

        idle(2);

        send(8'hA5, MODE_BPSK);
        idle(8 * SPS + 3);

        send(8'h1B, MODE_QPSK);
        idle(4 * SPS + 3);

        // Back-to-back QPSK with valid held high.
        accepted = 0;
        for (int k = 0; k < 60 && accepted < 2; k++) begin
            step(1'b1, (accepted == 0) ? 8'h00 : 8'hFF, MODE_QPSK);
            if (last_acc) accepted++;
        end
        if (accepted != 2) check("b2b_timeout", accepted, 2);
        idle(4 * SPS + 3);

        // Mode toggles every cycle while a BPSK byte is in flight.
        send(8'h3C, MODE_BPSK);
        m = MODE_BPSK;
        accepted = 0;
        for (int k = 0; k < 60 && accepted == 0; k++) begin
            m = ~m;
            step(1'b1, 8'h96, m);
            if (last_acc) accepted++;
        end
        if (accepted != 1) check("toggle_timeout", accepted, 1);
        idle(8 * SPS + 3);

        // Reset in the middle of a QPSK byte.
        send(8'hE4, MODE_QPSK);
        idle(4);
        do_reset();
        idle(10);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom));
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psk_modulator.md
PSK_MODULATOR -- requirements
Module: psk_modulator

Interface
REQ-001 Parameter WIDTH, default 16, is the signed I/Q sample width.
REQ-002 Parameter SPS, default 4, is the number of output samples per symbol (range 1..256).
REQ-003 Parameter AMP, default 8192, is the positive constellation amplitude, with 0 < AMP <= 2^(WIDTH-1)-1.
REQ-004 Port clk  in  1  is the single clock; all logic is rising-edge.
REQ-005 Port rst  in  1  is the reset, asynchronous and active-low.
REQ-006 Port mode  in  1  selects the modulation: 0 = BPSK, 1 = QPSK.
REQ-007 Port s_tdata  in  8  carries the payload byte.
REQ-008 Port s_tvalid  in  1  indicates that the payload byte is valid.
REQ-009 Port s_tready  out  1  indicates that the module accepts a byte in this cycle.
REQ-010 Port I_tdata  out  WIDTH  is the signed in-phase sample.
REQ-011 Port I_tvalid  out  1  indicates that the I sample is valid.
REQ-012 Port Q_tdata  out  WIDTH  is the signed quadrature sample.
REQ-013 Port Q_tvalid  out  1  indicates that the Q sample is valid; it is always equal to I_tvalid.
REQ-014 Port busy  out  1  is high while a byte is being transmitted.

Function
REQ-015 A byte SHALL be accepted on a rising edge where s_tvalid and s_tready are both 1; mode SHALL be sampled on the same edge and held for the whole byte.
REQ-016 The FSM SHALL have exactly two states: IDLE (s_tready=1, outputs invalid) and SEND (symbols being output).
REQ-017 IDLE -> SEND SHALL occur on acceptance; SEND -> IDLE SHALL occur after the last sample of the last symbol when no new byte is accepted on that edge.
REQ-018 Bits SHALL be consumed MSB first: BPSK uses 8 symbols of 1 bit each; QPSK uses 4 symbols of 2 bits {b_hi,b_lo}.
REQ-019 QPSK mapping SHALL be I = b_hi ? -AMP : +AMP and Q = b_lo ? -AMP : +AMP.
REQ-020 BPSK mapping SHALL be I = Q = bit ? -AMP : +AMP, so that sign(I+Q) recovers the bit.
REQ-021 Each symbol SHALL be held for exactly SPS consecutive cycles with I_tvalid=Q_tvalid=1; there is no output backpressure.
REQ-022 Latency SHALL be one cycle: the first sample of a byte is valid in the cycle after acceptance.
REQ-023 In SEND, s_tready SHALL be 1 only during the last sample of the last symbol; acceptance there SHALL start the next byte gap-free in the next cycle.
REQ-024 The next byte SHALL use the mode value sampled at its own acceptance; a mode change in mid-byte SHALL have no effect on the current byte.
REQ-025 On underflow (last sample reached and s_tvalid=0), the module SHALL enter IDLE, drive I_tdata=Q_tdata=0, and deassert the valid outputs in the next cycle.
REQ-026 The sample counter SHALL wrap from SPS-1 to 0; the symbol counter SHALL wrap at 7 (BPSK) or 3 (QPSK).
REQ-027 busy SHALL be 1 exactly when the state is SEND.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Asserting rst (0) SHALL asynchronously force: state=IDLE, counters=0, shift register=0, I_tdata=Q_tdata=0, I_tvalid=Q_tvalid=0, busy=0, s_tready=0.
REQ-030 s_tready SHALL rise to 1 on the first clock edge after rst is released.
REQ-031 A reset in mid-byte SHALL discard the remaining bits; no partial symbol SHALL be output after release.

Structure
REQ-032 Package psk_pkg SHALL hold the mode encoding (MODE_BPSK=0, MODE_QPSK=1), the FSM state type, and the default AMP constant.
REQ-033 The module SHALL instantiate one combinational sub-module, psk_symbol_map (mode, 2 bits -> I, Q), which is reusable by a receiver-side reference model.

Verification
REQ-034 BPSK, SPS=4, byte 0xA5 -> 32 valid samples; I=Q sequence -A,+A,-A,+A,+A,-A,+A,-A, each symbol held 4 cycles.
REQ-035 QPSK, SPS=4, byte 0x1B -> symbols (I,Q) = (+A,+A), (+A,-A), (-A,+A), (-A,-A), each held 4 cycles, 16 samples in total.
REQ-036 Back-to-back QPSK bytes 0x00 then 0xFF with s_tvalid held high -> 32 contiguous valid samples with no gap, and s_tready pulsing once per byte.
REQ-037 Single BPSK byte, then s_tvalid=0 -> after 8*SPS samples, valid drops and I=Q=0 in the next cycle, busy=0, and s_tready=1.
REQ-038 rst asserted at sample 5 of a QPSK byte -> outputs zero immediately and asynchronously; after release, no samples appear until a new byte is accepted.
REQ-039 mode toggled during a BPSK byte -> that byte stays BPSK (8 symbols), and the next byte uses the mode sampled at its acceptance.
